pipe_ctrl_regs: RTL and testbench

PIPE_CTRL_REGS -- requirements
Module: pipe_ctrl_regs

---
 rtl/pipe_ctrl_regs_pkg.sv | 47 ++++
 rtl/pipe_ctrl_regs_stage.sv | 28 ++
 rtl/pipe_ctrl_regs.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl_regs.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared CPU pipeline definitions: field widths, link register, next-PC
// encodings and the per-stage control records carried by the pipeline.
package pipe_ctrl_regs_pkg;

    localparam int ALUC_W = 4;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        PCS_SEQ    = 2'b00,
        PCS_BRANCH = 2'b01,
        PCS_JR     = 2'b10,
        PCS_JUMP   = 2'b11
    } pcsource_e;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              jal;
        logic              aluimm;
        logic              shift;
        logic [ALUC_W-1:0] aluc;
        logic [REG_W-1:0]  rn;
    } e_ctrl_t;

    typedef struct packed {
        logic             wreg;
        logic             m2reg;
        logic             wmem;
        logic [REG_W-1:0] rn;
    } m_ctrl_t;

    typedef struct packed {
        logic             wreg;
        logic             m2reg;
        logic [REG_W-1:0] rn;
    } w_ctrl_t;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pipe_ctrl_regs_stage.sv
// Generic pipeline stage register: asynchronous clear on reset and a
// synchronous clear used to inject a bubble.
module pipe_stage_reg #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;

    // Stage storage; clear takes precedence over capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= {N{1'b0}};
        end else if (clear) begin
            q_q <= {N{1'b0}};
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Control-signal pipeline registers (D->E->M->W) with load-use stall and
// control-transfer squash handling, plus saturating stall/bubble counters.
module pipe_ctrl_regs
    import pipe_ctrl_regs_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic              wmem,
    input  logic              jal,
    input  logic              regrt,
    input  logic              aluimm,
    input  logic              shift,
    input  logic              sext,
    input  logic [ALUC_W-1:0] aluc,
    input  logic [1:0]        pcsource,
    input  logic              wpcir,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rt,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ejal,
    output logic              ealuimm,
    output logic              eshift,
    output logic [ALUC_W-1:0] ealuc,
    output logic [REG_W-1:0]  ern,
    output logic              ebubble,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [REG_W-1:0]  mrn,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [REG_W-1:0]  wrn,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    e_ctrl_t          e_d;
    e_ctrl_t          e_q;
    m_ctrl_t          m_d;
    m_ctrl_t          m_q;
    w_ctrl_t          w_d;
    w_ctrl_t          w_q;
    logic [REG_W-1:0] drn_s;
    logic [REG_W-1:0] ern_s;
    logic             e_clear_s;
    logic             ebubble_d;
    logic             ebubble_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             sext_unused_s;

    // Sign-extension select only matters to the datapath in decode.
    assign sext_unused_s = sext;

    assign drn_s     = regrt ? rt : rd;
    assign e_clear_s = ~wpcir | ebubble_q;
    assign ern_s     = e_q.jal ? LINK_REG : e_q.rn;

    // Pack decode controls into the E-stage record.
    always_comb begin
        e_d        = '{default: 1'b0};
        e_d.wreg   = wreg;
        e_d.m2reg  = m2reg;
        e_d.wmem   = wmem;
        e_d.jal    = jal;
        e_d.aluimm = aluimm;
        e_d.shift  = shift;
        e_d.aluc   = aluc;
        e_d.rn     = drn_s;
    end

    // M and W simply follow the previous stage; mrn takes the resolved ern.
    always_comb begin
        m_d       = '{default: 1'b0};
        m_d.wreg  = e_q.wreg;
        m_d.m2reg = e_q.m2reg;
        m_d.wmem  = e_q.wmem;
        m_d.rn    = ern_s;
        w_d       = '{default: 1'b0};
        w_d.wreg  = m_q.wreg;
        w_d.m2reg = m_q.m2reg;
        w_d.rn    = m_q.rn;
    end

    pipe_stage_reg #(.N($bits(e_ctrl_t))) u_de (
        .clock (clock),
        .reset (reset),
        .clear (e_clear_s),
        .d     (e_d),
        .q     (e_q)
    );

    pipe_stage_reg #(.N($bits(m_ctrl_t))) u_em (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .d     (m_d),
        .q     (m_q)
    );

    pipe_stage_reg #(.N($bits(w_ctrl_t))) u_mw (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .d     (w_d),
        .q     (w_q)
    );

    // A stall freezes the squash flag so the pending squash still applies
    // once decode moves again; a squashed transfer cannot re-arm it.
    always_comb begin
        ebubble_d    = ebubble_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!wpcir) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            ebubble_d = (pcsource_e'(pcsource) != PCS_SEQ) && !ebubble_q;
            if (ebubble_q) begin
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end
    end

    // Squash flag and event counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ebubble_q    <= 1'b0;
            stall_cnt_q  <= 16'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            ebubble_q    <= ebubble_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ewreg      = e_q.wreg;
    assign em2reg     = e_q.m2reg;
    assign ewmem      = e_q.wmem;
    assign ejal       = e_q.jal;
    assign ealuimm    = e_q.aluimm;
    assign eshift     = e_q.shift;
    assign ealuc      = e_q.aluc;
    assign ern        = ern_s;
    assign ebubble    = ebubble_q;
    assign mwreg      = m_q.wreg;
    assign mm2reg     = m_q.m2reg;
    assign mwmem      = m_q.wmem;
    assign mrn        = m_q.rn;
    assign wwreg      = w_q.wreg;
    assign wm2reg     = w_q.m2reg;
    assign wrn        = w_q.rn;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Scoreboard bench for pipe_ctrl_regs: expected E-stage records are queued as
// decode stimulus is driven and compared after each capturing edge.
module tb_pipe_ctrl_regs;

    typedef struct packed {
        logic       wreg, m2reg, wmem, jal, regrt, aluimm, shift, sext;
        logic [3:0] aluc;
        logic [1:0] pcsource;
        logic       wpcir;
        logic [4:0] rd, rt;
    } d_t;

    typedef struct packed {
        logic       wreg, m2reg, wmem, jal, aluimm, shift;
        logic [3:0] aluc;
        logic [4:0] rn;
    } e_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wreg = 1'b0, m2reg = 1'b0, wmem = 1'b0, jal = 1'b0;
    logic        regrt = 1'b0, aluimm = 1'b0, shift = 1'b0, sext = 1'b0;
    logic [3:0]  aluc = 4'd0;
    logic [1:0]  pcsource = 2'd0;
    logic        wpcir = 1'b1;
    logic [4:0]  rd = 5'd0, rt = 5'd0;
    logic        ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ebubble;
    logic [3:0]  ealuc;
    logic [4:0]  ern, mrn, wrn;
    logic        mwreg, mm2reg, mwmem, wwreg, wm2reg;
    logic [15:0] stall_cnt, bubble_cnt;

    e_t          e_obs;
    logic [62:0] all_o;
    e_t          q_e[$];
    logic        mdl_ebubble = 1'b0;
    logic [15:0] mdl_stall = 16'd0;
    logic [15:0] mdl_bubble = 16'd0;
    int          n_pass = 0;
    int          n_total = 0;

    assign e_obs = {ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern};
    assign all_o = {e_obs, ebubble, mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn,
                    stall_cnt, bubble_cnt};

    pipe_ctrl_regs dut (
        .clock(clock), .reset(reset),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .jal(jal), .regrt(regrt),
        .aluimm(aluimm), .shift(shift), .sext(sext), .aluc(aluc),
        .pcsource(pcsource), .wpcir(wpcir), .rd(rd), .rt(rt),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal),
        .ealuimm(ealuimm), .eshift(eshift), .ealuc(ealuc), .ern(ern),
        .ebubble(ebubble), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mrn(mrn), .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic apply(input d_t d);
        wreg = d.wreg; m2reg = d.m2reg; wmem = d.wmem; jal = d.jal;
        regrt = d.regrt; aluimm = d.aluimm; shift = d.shift; sext = d.sext;
        aluc = d.aluc; pcsource = d.pcsource; wpcir = d.wpcir; rd = d.rd; rt = d.rt;
    endtask

    // Drive decode inputs and queue the E record they should produce.
    task automatic drive(input d_t d);
        e_t e;
        apply(d);
        e = '0;
        if (d.wpcir && !mdl_ebubble) begin
            e.wreg = d.wreg; e.m2reg = d.m2reg; e.wmem = d.wmem; e.jal = d.jal;
            e.aluimm = d.aluimm; e.shift = d.shift; e.aluc = d.aluc;
            e.rn = d.jal ? 5'd31 : (d.regrt ? d.rt : d.rd);
        end
        q_e.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        if (!wpcir) mdl_stall = sat16(mdl_stall);
        else if (mdl_ebubble) mdl_bubble = sat16(mdl_bubble);
        if (wpcir) mdl_ebubble = (pcsource != 2'b00) && !mdl_ebubble;
        #1;
    endtask

    function automatic d_t nop();
        d_t d;
        d = '0;
        d.wpcir = 1'b1;
        return d;
    endfunction

    task automatic test_reset();
        d_t d;
        d = nop();
        d.wreg = 1'b1; d.wmem = 1'b1; d.rd = 5'd7; d.pcsource = 2'b01;
        apply(d);
        #1;
        n_total++;
        if (all_o !== 63'd0) $display("FAIL reset_initial: outputs=%h expected 0", all_o);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (all_o !== 63'd0) $display("FAIL reset_held: outputs=%h expected 0", all_o);
        else n_pass++;
        apply(nop());
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_add_latency();
        d_t d;
        e_t exp;
        d = nop();
        d.wreg = 1'b1; d.rd = 5'd5; d.rt = 5'd9; d.aluc = 4'd0;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ern !== 5'd5 || ewreg !== 1'b1)
            $display("FAIL add_e: E=%h expected %h (ern=%0d)", e_obs, exp, ern);
        else n_pass++;
        drive(nop());
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (mrn !== 5'd5 || mwreg !== 1'b1 || e_obs !== exp)
            $display("FAIL add_m: mrn=%0d mwreg=%b expected 5 1", mrn, mwreg);
        else n_pass++;
        drive(nop());
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (wrn !== 5'd5 || wwreg !== 1'b1 || e_obs !== exp)
            $display("FAIL add_w: wrn=%0d wwreg=%b expected 5 1", wrn, wwreg);
        else n_pass++;
    endtask

    task automatic test_load_use();
        d_t d;
        e_t exp;
        d = nop();
        d.wreg = 1'b1; d.m2reg = 1'b1; d.regrt = 1'b1; d.rt = 5'd8; d.rd = 5'd3;
        d.aluimm = 1'b1; d.sext = 1'b1; d.aluc = 4'd2;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ern !== 5'd8 || em2reg !== 1'b1)
            $display("FAIL lw_e: E=%h expected %h", e_obs, exp);
        else n_pass++;
        d = nop();
        d.wreg = 1'b1; d.rd = 5'd9; d.wpcir = 1'b0;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ewreg !== 1'b0 || stall_cnt !== 16'd1)
            $display("FAIL lw_stall: E=%h stall_cnt=%0d expected %h 1", e_obs, stall_cnt, exp);
        else n_pass++;
        d.wpcir = 1'b1;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ern !== 5'd9 || ewreg !== 1'b1)
            $display("FAIL lw_resume: E=%h expected %h", e_obs, exp);
        else n_pass++;
    endtask

    task automatic test_branch_squash();
        d_t d;
        e_t exp;
        d = nop();
        d.pcsource = 2'b01; d.aluc = 4'd1; d.rd = 5'd2;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ebubble !== 1'b1)
            $display("FAIL beq_e: E=%h ebubble=%b expected %h 1", e_obs, ebubble, exp);
        else n_pass++;
        d = nop();
        d.wreg = 1'b1; d.rd = 5'd7; d.pcsource = 2'b10;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ewreg !== 1'b0)
            $display("FAIL squash_e: E=%h expected %h", e_obs, exp);
        else n_pass++;
        n_total++;
        if (ebubble !== 1'b0 || bubble_cnt !== 16'd1)
            $display("FAIL squash_flag: ebubble=%b bubble_cnt=%0d expected 0 1", ebubble, bubble_cnt);
        else n_pass++;
        drive(nop());
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp) $display("FAIL post_squash: E=%h expected %h", e_obs, exp);
        else n_pass++;
    endtask

    task automatic test_jal();
        d_t d;
        e_t exp;
        d = nop();
        d.jal = 1'b1; d.wreg = 1'b1; d.rd = 5'd0; d.pcsource = 2'b11;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ern !== 5'd31 || ejal !== 1'b1)
            $display("FAIL jal_e: ern=%0d ejal=%b expected 31 1", ern, ejal);
        else n_pass++;
        drive(nop());
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (mrn !== 5'd31 || mwreg !== 1'b1 || e_obs !== exp)
            $display("FAIL jal_m: mrn=%0d mwreg=%b expected 31 1", mrn, mwreg);
        else n_pass++;
        n_total++;
        if (bubble_cnt !== mdl_bubble || ebubble !== mdl_ebubble)
            $display("FAIL jal_bubble: bubble_cnt=%0d ebubble=%b expected %0d %b",
                     bubble_cnt, ebubble, mdl_bubble, mdl_ebubble);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        d_t d;
        e_t exp;
        drive(nop());
        tick();
        void'(q_e.pop_front());
        d = nop();
        d.wreg = 1'b1; d.wmem = 1'b1; d.rd = 5'd4;
        drive(d);
        tick();
        void'(q_e.pop_front());
        d.rd = 5'd6;
        drive(d);
        tick();
        void'(q_e.pop_front());
        drive(nop());
        tick();
        void'(q_e.pop_front());
        n_total++;
        if (mwreg !== 1'b1 || wwreg !== 1'b1 || mwmem !== 1'b1)
            $display("FAIL pre_reset: mwreg=%b wwreg=%b expected 1 1", mwreg, wwreg);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (all_o !== 63'd0) $display("FAIL async_reset: outputs=%h expected 0", all_o);
        else n_pass++;
        q_e.delete();
        mdl_ebubble = 1'b0; mdl_stall = 16'd0; mdl_bubble = 16'd0;
        @(negedge clock);
        reset = 1'b0;
        d = nop();
        d.wreg = 1'b1; d.rd = 5'd5;
        drive(d);
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ern !== 5'd5 || stall_cnt !== 16'd0)
            $display("FAIL resume_capture: E=%h expected %h", e_obs, exp);
        else n_pass++;
    endtask

    task automatic test_stall_saturation();
        d_t d;
        e_t exp;
        int bad_e = 0;
        int bad_b = 0;
        logic [15:0] bub0;
        d = nop();
        d.pcsource = 2'b01;
        drive(d);
        tick();
        void'(q_e.pop_front());
        bub0 = bubble_cnt;
        for (int i = 0; i < 70000; i++) begin
            d = nop();
            d.wpcir = 1'b0;
            d.wreg = 1'b1;
            d.pcsource = 2'($urandom_range(0, 3));
            d.rd = 5'($urandom_range(0, 31));
            drive(d);
            tick();
            exp = q_e.pop_front();
            if (e_obs !== exp) bad_e++;
            if (ebubble !== 1'b1) bad_b++;
            if (i == 65533) begin
                n_total++;
                if (stall_cnt !== 16'hFFFE)
                    $display("FAIL stall_near_sat: stall_cnt=%h expected fffe", stall_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if (stall_cnt !== 16'hFFFF || stall_cnt !== mdl_stall)
            $display("FAIL stall_sat: stall_cnt=%h expected ffff", stall_cnt);
        else n_pass++;
        n_total++;
        if (bad_b != 0 || bad_e != 0 || bubble_cnt !== bub0)
            $display("FAIL stall_priority: ebubble_bad=%0d e_bad=%0d bubble_cnt=%0d expected 0 0 %0d",
                     bad_b, bad_e, bubble_cnt, bub0);
        else n_pass++;
        drive(nop());
        tick();
        exp = q_e.pop_front();
        n_total++;
        if (e_obs !== exp || ebubble !== 1'b0 || bubble_cnt !== mdl_bubble || stall_cnt !== 16'hFFFF)
            $display("FAIL stall_release: ebubble=%b bubble_cnt=%0d expected 0 %0d",
                     ebubble, bubble_cnt, mdl_bubble);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_load_use();
        test_branch_squash();
        test_jal();
        test_async_reset();
        test_stall_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
